reg_bank_write_arbiter: RTL and testbench
=========================================

Name: reg_bank_write_arbiter

Overview:
- Shares one bank of four 8-bit storage registers between four independent write requesters.
- Round-robin arbitration with a registered one-cycle grant pulse.
- Exactly one write per clock at most, plus an asynchronous-free combinational read port.
- Sits between the datapath units and the 8-bit register storage; it sequences and serialises all writes into the bank.

Parameters:
- WIDTH, 8, data width of each register entry and each requester data lane.
- NUM_REQ, 4, number of requesters. Fixed at 4; other values are unsupported.
- NUM_REGS, 4, number of register entries in the bank. Addressed by 2 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  write request per requester; bit i = requester i.
- wr_addr  input  8  flattened target addresses; bits [2i+1:2i] belong to requester i.
- wr_data  input  32  flattened write data; bits [8i+7:8i] belong to requester i.
- hold  input  1  when 1, no new grant is issued and no write occurs.
- rd_addr  input  2  read address.
- rd_data  output  8  combinational read of reg[rd_addr].
- gnt  output  4  registered one-hot grant pulse; high for exactly one cycle after the write edge.
- busy  output  1  registered; 1 in any cycle where a grant is being presented.
- wr_count  output  8  registered count of completed writes; wraps 255 -> 0.

Behaviour:
- Reset (rst_n=0, asynchronous, any time):
  - All bank entries = 8'h00; gnt = 4'b0000; busy = 0; wr_count = 0.
  - Round-robin pointer last = 3, so requester 0 has first priority.
  - Reset asserted mid-grant clears gnt immediately.
  - The first edge after rst_n rises performs normal arbitration.
- Eligibility each cycle: eligible[i] = req[i] & ~gnt[i].
  - A requester seen granted in the current cycle is masked for that cycle, which prevents a double write while it lowers req.
- Arbitration on each rising edge, when hold=0 and eligible != 0:
  - Winner w = first eligible index scanning last+1, last+2, ... modulo 4.
  - reg[wr_addr lane w] <= wr_data lane w.
  - gnt <= one-hot(w); busy <= 1; last <= w; wr_count <= wr_count + 1 (mod 256).
- Idle edge (hold=1 or eligible=0):
  - gnt <= 0; busy <= 0; bank, last and wr_count unchanged.
  - hold has no effect on a grant already presented; that grant still ends after its one cycle.
- Handshake rules:
  - A requester keeps req, addr and data stable until it sees gnt[i]=1.
  - Data was committed on the edge that raised gnt[i].
  - The requester may drop req in the gnt cycle, or keep it high for another write.
  - A lone requester holding req continuously is granted every other cycle: pattern gnt=1,0,1,0.
  - With two or more requesters active, grants are issued back-to-back with rotation.
- Collisions:
  - Two requesters targeting the same address are serialised; the later grant's data remains.
  - There is no same-cycle merge.
- Read port:
  - rd_data = reg[rd_addr], purely combinational.
  - A read of the address being written shows the old value until the write edge, then the new value (no bypass).
- Fairness: any continuously requesting requester is granted within 4 grant slots (at most 7 cycles when hold=0).

Test Plan:
- Reset then single write:
  - Stimulus: req=0001, addr0=2, data0=8'hD6, held until gnt.
  - Required: gnt=0001 for 1 cycle; reg[2]=D6; wr_count=1; rd_addr=2 reads D6; all other entries read 00.
- All four requesting:
  - Stimulus: req=1111 held continuously from reset; data lanes 11,22,33,44; addresses 0,1,2,3.
  - Required: grant order 0,1,2,3,0,... on consecutive cycles; after 4 cycles the bank holds 11,22,33,44; wr_count=4.
- Collision:
  - Stimulus: requesters 1 and 2 both target addr 0 with 9C and 5A; last=0.
  - Required: gnt 0010 then 0100; final reg[0]=5A.
- Hold:
  - Stimulus: hold=1 for 5 cycles with req=0100.
  - Required: gnt=0, busy=0, no bank change during hold; on the first edge after hold drops, gnt=0100.
- Reset mid-operation:
  - Stimulus: rst_n pulled low while gnt=1000.
  - Required: gnt, busy and wr_count clear immediately without waiting for a clock edge; the bank reads 00.
- Lone continuous requester and wrap:
  - Stimulus: req=0001 held for 512 cycles.
  - Required: gnt alternates 1,0; wr_count reaches 255 then wraps to 0.

Source files
------------

// File: rtl/reg_bank_write_arbiter.sv
// reg_bank_write_arbiter
//
// Serialises writes from four requesters into a shared bank of four registers.
// A round-robin arbiter picks at most one requester per rising edge. The write is
// committed on that edge, and a one-cycle one-hot grant pulse is presented afterwards.
//
// Ports
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset
//   req_i       write request per requester (bit i = requester i)
//   wr_addr_i   flattened addresses, lane i = [AddrW*i +: AddrW]
//   wr_data_i   flattened data, lane i = [WIDTH*i +: WIDTH]
//   hold_i      suppresses new grants and writes while high
//   rd_addr_i   combinational read address
//   rd_data_o   bank[rd_addr_i], no write bypass
//   gnt_o       registered one-hot grant pulse
//   busy_o      high while a grant is presented
//   wr_count_o  completed-write counter, wraps modulo 256
module reg_bank_write_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned NUM_REGS = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NUM_REQ-1:0]                 req_i,
  input  logic [NUM_REQ*$clog2(NUM_REGS)-1:0] wr_addr_i,
  input  logic [NUM_REQ*WIDTH-1:0]           wr_data_i,
  input  logic                               hold_i,
  input  logic [$clog2(NUM_REGS)-1:0]        rd_addr_i,
  output logic [WIDTH-1:0]                   rd_data_o,
  output logic [NUM_REQ-1:0]                 gnt_o,
  output logic                               busy_o,
  output logic [7:0]                         wr_count_o
);

  localparam int unsigned AddrW   = $clog2(NUM_REGS);
  localparam int unsigned ReqIdxW = $clog2(NUM_REQ);

  logic [WIDTH-1:0]   bank_q [NUM_REGS];
  logic [WIDTH-1:0]   bank_d [NUM_REGS];
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic [ReqIdxW-1:0] last_q, last_d;
  logic [7:0]         count_q, count_d;

  logic [NUM_REQ-1:0] eligible;
  logic               win_found;
  logic [ReqIdxW-1:0] win_idx;
  logic [ReqIdxW-1:0] cand;
  logic               do_write;

  // A requester whose grant is on the bus this cycle is masked, so it cannot be
  // written twice while it is still lowering req.
  assign eligible = req_i & ~gnt_q;

  // Rotating priority: scan last+1, last+2, ... wrapping around the requesters.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = ReqIdxW'((32'(last_q) + k) % NUM_REQ);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign do_write = win_found & ~hold_i;

  always_comb begin
    bank_d  = bank_q;
    gnt_d   = '0;
    busy_d  = 1'b0;
    last_d  = last_q;
    count_d = count_q;
    if (do_write) begin
      bank_d[wr_addr_i[win_idx*AddrW +: AddrW]] = wr_data_i[win_idx*WIDTH +: WIDTH];
      gnt_d[win_idx] = 1'b1;
      busy_d         = 1'b1;
      last_d         = win_idx;
      count_d        = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        bank_q[i] <= '0;
      end
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      // Last winner = highest index so requester 0 has first priority.
      last_q  <= ReqIdxW'(NUM_REQ - 1);
      count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        bank_q[i] <= bank_d[i];
      end
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  assign rd_data_o  = bank_q[rd_addr_i];
  assign gnt_o      = gnt_q;
  assign busy_o     = busy_q;
  assign wr_count_o = count_q;

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
`timescale 1ns/1ps
module tb_reg_bank_write_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [3:0]  req_i;
  logic [7:0]  wr_addr_i;
  logic [31:0] wr_data_i;
  logic        hold_i;
  logic [1:0]  rd_addr_i;
  logic [7:0]  rd_data_o;
  logic [3:0]  gnt_o;
  logic        busy_o;
  logic [7:0]  wr_count_o;

  reg_bank_write_arbiter dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .hold_i     (hold_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .gnt_o      (gnt_o),
    .busy_o     (busy_o),
    .wr_count_o (wr_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0] id;
    logic [1:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t         sb[$];
  logic [7:0]  shadow [4];
  logic [7:0]  shadow_cnt;
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic clear_model();
    for (int a = 0; a < 4; a++) shadow[a] = 8'h00;
    shadow_cnt = 8'd0;
  endtask

  task automatic set_lane(input int i, input logic [1:0] addr, input logic [7:0] data);
    wr_addr_i[2*i +: 2] = addr;
    wr_data_i[8*i +: 8] = data;
  endtask

  task automatic push_lane(input int i);
    wr_t w;
    w.id   = 2'(i);
    w.addr = wr_addr_i[2*i +: 2];
    w.data = wr_data_i[8*i +: 8];
    sb.push_back(w);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
    rd_addr_i = a;
    #1;
    chk(tag, rd_data_o, exp);
  endtask

  task automatic check_bank(input string tag);
    for (int a = 0; a < 4; a++) rd_chk(tag, 2'(a), shadow[a]);
  endtask

  // Scoreboard consumer: every grant must match the oldest expected write.
  always begin
    @(posedge clk_i);
    #1;
    if (gnt_o !== 4'b0000) begin
      if (sb.size() == 0) begin
        chk("spurious_gnt", gnt_o, 4'b0000);
      end else begin
        wr_t w;
        w = sb.pop_front();
        chk("sb_gnt", gnt_o, 4'b0001 << w.id);
        shadow[w.addr] = w.data;
        shadow_cnt     = shadow_cnt + 8'd1;
        chk("sb_count", wr_count_o, shadow_cnt);
      end
    end
  end

  initial begin
    rst_ni    = 1'b0;
    req_i     = 4'b0000;
    wr_addr_i = 8'h00;
    wr_data_i = 32'h0;
    hold_i    = 1'b0;
    rd_addr_i = 2'd0;
    clear_model();

    // Reset state
    tick();
    tick();
    chk("rst_gnt", gnt_o, 4'b0000);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_count", wr_count_o, 8'd0);
    for (int a = 0; a < 4; a++) rd_chk("rst_bank", 2'(a), 8'h00);
    rst_ni = 1'b1;

    // Single write from requester 0
    tick();
    req_i = 4'b0001;
    set_lane(0, 2'd2, 8'hD6);
    push_lane(0);
    tick();
    chk("single_gnt", gnt_o, 4'b0001);
    chk("single_busy", busy_o, 1'b1);
    req_i = 4'b0000;
    tick();
    chk("single_gnt_end", gnt_o, 4'b0000);
    chk("single_busy_end", busy_o, 1'b0);
    chk("single_count", wr_count_o, 8'd1);
    rd_chk("single_rd2", 2'd2, 8'hD6);
    rd_chk("single_rd0", 2'd0, 8'h00);
    check_bank("single_bank");

    // All four requesting from reset, then reset while gnt=1000
    rst_ni = 1'b0;
    clear_model();
    req_i     = 4'b1111;
    wr_addr_i = 8'b11_10_01_00;
    wr_data_i = 32'h44332211;
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) push_lane(i);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_gnt", gnt_o, 4'b0001 << i);
      chk("rr_busy", busy_o, 1'b1);
    end
    chk("rr_count", wr_count_o, 8'd4);
    rd_chk("rr_rd0", 2'd0, 8'h11);
    rd_chk("rr_rd1", 2'd1, 8'h22);
    rd_chk("rr_rd2", 2'd2, 8'h33);
    rd_chk("rr_rd3", 2'd3, 8'h44);
    chk("rr_gnt_last", gnt_o, 4'b1000);
    req_i  = 4'b0000;
    rst_ni = 1'b0;
    #1;
    chk("arst_gnt", gnt_o, 4'b0000);
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_count", wr_count_o, 8'd0);
    for (int a = 0; a < 4; a++) rd_chk("arst_bank", 2'(a), 8'h00);
    clear_model();
    tick();
    rst_ni = 1'b1;

    // Collision on address 0 with last=0
    req_i = 4'b0001;
    set_lane(0, 2'd1, 8'h77);
    push_lane(0);
    tick();
    chk("pre_gnt", gnt_o, 4'b0001);
    req_i = 4'b0110;
    set_lane(1, 2'd0, 8'h9C);
    set_lane(2, 2'd0, 8'h5A);
    push_lane(1);
    push_lane(2);
    tick();
    chk("col_gnt1", gnt_o, 4'b0010);
    req_i = 4'b0100;
    tick();
    chk("col_gnt2", gnt_o, 4'b0100);
    req_i = 4'b0000;
    tick();
    chk("col_idle", gnt_o, 4'b0000);
    rd_chk("col_rd0", 2'd0, 8'h5A);
    check_bank("col_bank");

    // Hold for five cycles with requester 2 pending
    hold_i = 1'b1;
    req_i  = 4'b0100;
    set_lane(2, 2'd3, 8'hE1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_gnt", gnt_o, 4'b0000);
      chk("hold_busy", busy_o, 1'b0);
      chk("hold_count", wr_count_o, 8'd3);
      rd_chk("hold_rd3", 2'd3, 8'h00);
    end
    hold_i = 1'b0;
    push_lane(2);
    tick();
    chk("hold_release_gnt", gnt_o, 4'b0100);
    req_i = 4'b0000;
    tick();
    rd_chk("hold_rd3_after", 2'd3, 8'hE1);

    // Lone continuous requester: alternating grants and counter wrap
    rst_ni = 1'b0;
    clear_model();
    req_i = 4'b0001;
    set_lane(0, 2'd1, 8'h00);
    tick();
    rst_ni = 1'b1;
    for (int c = 0; c < 512; c++) begin
      if (c % 2 == 0) push_lane(0);
      tick();
      chk("lone_gnt", gnt_o, (c % 2 == 0) ? 4'b0001 : 4'b0000);
      if (c == 508) chk("lone_count_255", wr_count_o, 8'd255);
      if (c == 510) chk("lone_count_wrap", wr_count_o, 8'd0);
      if (c % 2 == 0) wr_data_i[7:0] = 8'(c / 2 + 1);
    end
    req_i = 4'b0000;
    tick();
    chk("end_gnt", gnt_o, 4'b0000);
    chk("end_sb_empty", 32'(sb.size()), 32'd0);
    check_bank("end_bank");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
